clk_en_scheduler: RTL and testbench
===================================

// Module: clk_en_scheduler
// PURPOSE
//  Arbitrates NUM_CH slow clock/strobe inputs onto one shared downstream engine (LED frame/shift datapath).
//  Each channel rising edge becomes a one-clk_in-cycle enable, queued per channel and issued round-robin.
//  At most one request is in flight at a time; completion is handshaken via done_in or a timeout.
// PARAMETERS
//  NUM_CH       4    number of slow-clock requester channels (2..16)
//  SYNC_STAGES  2    synchronizer flops per slow_clk_in bit (>=2)
//  PEND_W       2    pending-count width per channel; saturates at 2**PEND_W-1
//  TIMEOUT      255  max clk_in cycles in WAIT_DONE before forced release (>=1)
// PORTS
//  clk_in           in   1        single system clock; all logic on posedge
//  rst_n_in         in   1        reset, asynchronous assert, active-low
//  slow_clk_in      in   NUM_CH   per-channel slow clock/strobe, asynchronous to clk_in
//  ch_enable_in     in   NUM_CH   1 = channel participates; 0 = edges ignored, pending cleared
//  ready_in         in   1        downstream can accept a new enable this cycle
//  done_in          in   1        downstream finished current job (1-cycle pulse)
//  ovf_clr_in       in   1        clears ovf_out and timeout_out
//  en_out           out  NUM_CH   one-hot 1-cycle enable to downstream
//  busy_out         out  1        1 while a job is in flight (ISSUE or WAIT_DONE)
//  ovf_out          out  NUM_CH   sticky: edge arrived while channel pending count saturated
//  timeout_out      out  1        sticky: a job was released by timeout
// BEHAVIOUR
//  Reset (rst_n_in=0, async): sync flops, edge-prev flops, pending counts, rr pointer -> 0; FSM IDLE;
//   en_out=0, busy_out=0, ovf_out=0, timeout_out=0. Reset mid-job drops job and all pending counts.
//  Edge detect: rise = sync_last & ~prev; a channel already high at reset release counts as one edge.
//  Pending per channel: +1 on rise (enabled only), -1 on grant; rise+grant same cycle -> unchanged.
//   At max with rise and no grant: count stays max, ovf_out[ch] set. ch_enable_in=0 forces count to 0.
//  Eligible: pending>0 & ch_enable_in. Round-robin search starts at ptr+1 mod NUM_CH; ptr := granted ch.
//  FSM (registered outputs):
//   IDLE: if any eligible & ready_in -> ISSUE; latch winner, decrement its pending.
//   ISSUE: en_out=onehot(winner) for exactly 1 cycle, busy_out=1 -> WAIT_DONE; timer := 0.
//   WAIT_DONE: busy_out=1; done_in -> IDLE; else timer==TIMEOUT-1 -> IDLE, timeout_out set; else timer++.
//  done_in outside WAIT_DONE ignored. ready_in only sampled in IDLE.
//  Latency: slow_clk_in rise sampled at edge k -> en_out high after edge k+SYNC_STAGES+2 (idle, ready).
//  Next job earliest: en_out can re-assert 2 cycles after done_in cycle (IDLE then ISSUE).
//  ovf_clr_in: clears stickies; simultaneous set event wins over clear.
//  Channel disabled while its job in flight: job completes normally.
// STRUCTURE
//  Package clk_en_sched_pkg: FSM state enum (IDLE, ISSUE, WAIT_DONE), CH_IDX_W = $clog2(NUM_CH),
//   timer width function; rr next-winner function.
//  Sub-module clk_en_edge_sync: SYNC_STAGES synchronizer + prev flop + rise output; one instance per channel.
//  Top: generate loop of edge_sync, pending counters, rr arbiter, FSM + timer, sticky flags.
// TESTING
//  Single edge: ch1 rises, ready_in=1 -> en_out=4'b0010 one cycle at k+4; done_in 3 cyc later -> busy_out=0.
//  Fairness: ch0..ch3 rise same cycle, done_in 1 cyc after each en_out -> grants order 0,1,2,3 from ptr=3.
//  Saturation: 4 rises on ch2 with ready_in=0 -> pending=3, ovf_out=4'b0100; ovf_clr_in -> ovf_out=0.
//  Timeout: TIMEOUT=8, no done_in -> IDLE after 8 WAIT_DONE cycles, timeout_out=1, next pending issues.
//  Disable: ch0 pending=2, ch_enable_in[0]=0 -> count 0, no en_out[0]; rises while disabled ignored.
//  Async reset during WAIT_DONE with pending on ch3 -> all outputs 0 immediately; no en_out after release.

Source files
------------

// File: rtl/clk_en_sched_pkg.sv
// Shared types and helpers for the clock-enable scheduler: FSM state encoding,
// index/timer width helpers and the round-robin next-winner search.
package clk_en_sched_pkg;

  // Upper bound on channel count; the arbiter search is sized for this.
  localparam int unsigned MAX_CH       = 16;
  localparam int unsigned CH_IDX_MAX_W = 4;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitDone = 2'd2
  } sched_state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    int unsigned w;
    w = 1;
    if (num_ch > 2) begin
      w = $clog2(num_ch);
    end
    return w;
  endfunction

  // Width of the WAIT_DONE timer, which counts 0 .. timeout-1.
  function automatic int unsigned timer_w(input int unsigned timeout);
    int unsigned w;
    w = 1;
    if (timeout > 2) begin
      w = $clog2(timeout);
    end
    return w;
  endfunction

  // First eligible channel searching upward from ptr+1, wrapping at num_ch.
  // ptr itself is checked last, so a lone requester can still win back-to-back.
  function automatic logic [CH_IDX_MAX_W-1:0] rr_next(
    input logic [MAX_CH-1:0]       elig,
    input logic [CH_IDX_MAX_W-1:0] ptr,
    input int unsigned             num_ch
  );
    logic [CH_IDX_MAX_W-1:0] win;
    logic                    found;
    int unsigned             idx;
    win   = ptr;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      idx = {{(32 - CH_IDX_MAX_W){1'b0}}, ptr} + i;
      if (idx >= num_ch) begin
        idx = idx - num_ch;
      end
      if (!found && (i <= num_ch) && elig[idx[CH_IDX_MAX_W-1:0]]) begin
        win   = idx[CH_IDX_MAX_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/clk_en_edge_sync.sv
// Brings one asynchronous slow clock/strobe into the clk_i domain and emits a
// registered single-cycle pulse on each synchronised rising edge.
module clk_en_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  // Synchroniser chain, previous-level flop and registered rise detect.
  // prev_q resets low, so an input already high at reset release yields one edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/clk_en_scheduler.sv
// Arbitrates NUM_CH slow clock/strobe requesters onto one shared downstream
// engine. Each synchronised rising edge queues one job for its channel; jobs
// are issued round-robin as one-cycle enables, one in flight at a time, and
// released by done_in or by a timeout.
module clk_en_scheduler
  import clk_en_sched_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PEND_W      = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [NUM_CH-1:0] slow_clk_in,
  input  logic [NUM_CH-1:0] ch_enable_in,
  input  logic              ready_in,
  input  logic              done_in,
  input  logic              ovf_clr_in,
  output logic [NUM_CH-1:0] en_out,
  output logic              busy_out,
  output logic [NUM_CH-1:0] ovf_out,
  output logic              timeout_out
);

  localparam int unsigned        CH_IDX_W   = ch_idx_w(NUM_CH);
  localparam int unsigned        TIMER_W    = timer_w(TIMEOUT);
  localparam logic [PEND_W-1:0]  PEND_MAX   = {PEND_W{1'b1}};
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  logic [NUM_CH-1:0]   rise;
  logic [NUM_CH-1:0]   eligible;
  logic [NUM_CH-1:0]   grant_vec;
  logic [NUM_CH-1:0]   ovf_set;
  logic                grant_fire;
  logic [CH_IDX_W-1:0] winner;

  sched_state_e        state_q;
  logic [CH_IDX_W-1:0] ptr_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [NUM_CH-1:0]   en_q;
  logic                busy_q;
  logic [NUM_CH-1:0]   ovf_q;
  logic                timeout_q;

  // A grant happens only from IDLE, with the downstream ready and work queued.
  assign grant_fire = (state_q == StIdle) & ready_in & (|eligible);
  assign winner     = CH_IDX_W'(rr_next(MAX_CH'(eligible), CH_IDX_MAX_W'(ptr_q), NUM_CH));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;
    logic              rise_ok;
    logic              ovf_hit;

    clk_en_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
      .clk_i  (clk_in),
      .rst_ni (rst_n_in),
      .async_i(slow_clk_in[g]),
      .rise_o (rise[g])
    );

    assign rise_ok      = rise[g] & ch_enable_in[g];
    assign eligible[g]  = ch_enable_in[g] & (pend_q != '0);
    assign grant_vec[g] = grant_fire & (winner == CH_IDX_W'(g));
    assign ovf_set[g]   = ovf_hit;

    // Pending count: +1 per accepted edge, -1 per grant, cleared while disabled.
    always_comb begin
      pend_d  = pend_q;
      ovf_hit = 1'b0;
      if (!ch_enable_in[g]) begin
        pend_d = '0;
      end else if (rise_ok && !grant_vec[g]) begin
        if (pend_q == PEND_MAX) begin
          ovf_hit = 1'b1;
        end else begin
          pend_d = pend_q + 1'b1;
        end
      end else if (!rise_ok && grant_vec[g]) begin
        pend_d = pend_q - 1'b1;
      end
    end

    // Pending count register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        pend_q <= '0;
      end else begin
        pend_q <= pend_d;
      end
    end
  end

  // Sticky overflow flags; a new overflow in the clear cycle stays set.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~{NUM_CH{ovf_clr_in}}) | ovf_set;
    end
  end

  // Issue FSM with job timer, round-robin pointer and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      timer_q   <= '0;
      en_q      <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      en_q <= '0;
      if (ovf_clr_in) begin
        timeout_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (grant_fire) begin
            state_q <= StIssue;
            ptr_q   <= winner;
            en_q    <= grant_vec;
            busy_q  <= 1'b1;
          end
        end
        StIssue: begin
          state_q <= StWaitDone;
          timer_q <= '0;
        end
        StWaitDone: begin
          if (done_in) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (timer_q == TIMER_LAST) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign en_out      = en_q;
  assign busy_out    = busy_q;
  assign ovf_out     = ovf_q;
  assign timeout_out = timeout_q;

endmodule

// File: tb/tb_clk_en_scheduler.sv
// Directed bench for clk_en_scheduler: expected grants (channel and, where
// known, cycle) are queued as stimulus is applied and checked as en_out fires.
module tb_clk_en_scheduler;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned PEND_W      = 2;
  localparam int unsigned TIMEOUT     = 8;

  logic              clk_in = 1'b0;
  logic              rst_n_in = 1'b0;
  logic [NUM_CH-1:0] slow_clk_in = '0;
  logic [NUM_CH-1:0] ch_enable_in = '1;
  logic              ready_in = 1'b1;
  logic              done_in = 1'b0;
  logic              ovf_clr_in = 1'b0;
  logic [NUM_CH-1:0] en_out;
  logic              busy_out;
  logic [NUM_CH-1:0] ovf_out;
  logic              timeout_out;

  clk_en_scheduler #(
    .NUM_CH     (NUM_CH),
    .SYNC_STAGES(SYNC_STAGES),
    .PEND_W     (PEND_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .slow_clk_in (slow_clk_in),
    .ch_enable_in(ch_enable_in),
    .ready_in    (ready_in),
    .done_in     (done_in),
    .ovf_clr_in  (ovf_clr_in),
    .en_out      (en_out),
    .busy_out    (busy_out),
    .ovf_out     (ovf_out),
    .timeout_out (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [NUM_CH-1:0] en;
    int                cyc;  // -1: any cycle
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every enable must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (en_out !== '0) begin
      if (sb.size() == 0) begin
        check("en_unexpected", 32'(en_out), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("en_channel", 32'(en_out), 32'(mon_e.en));
        if (mon_e.cyc >= 0) check("en_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic raise(input logic [NUM_CH-1:0] m, output int at);
    @(negedge clk_in);
    slow_clk_in = slow_clk_in | m;
    at = cyc;
  endtask

  task automatic lower_all();
    @(negedge clk_in);
    slow_clk_in = '0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic pulse_edge(input logic [NUM_CH-1:0] m);
    int at;
    raise(m, at);
    repeat (3) @(negedge clk_in);
    lower_all();
  endtask

  task automatic wait_en(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk_in);
      if (en_out !== '0) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic job_done(input int d);
    check("busy_in_flight", 32'(busy_out), 32'd1);
    repeat (d) @(negedge clk_in);
    done_in = 1'b1;
    @(negedge clk_in);
    done_in = 1'b0;
    check("busy_released", 32'(busy_out), 32'd0);
  endtask

  task automatic check_none(input int n, input string tag);
    bit any;
    any = 1'b0;
    repeat (n) begin
      @(negedge clk_in);
      if (en_out !== '0) any = 1'b1;
    end
    check(tag, 32'(any), 32'd0);
  endtask

  initial begin
    int at;
    int e0;
    // Reset with ch0 already high: counts as one edge at release.
    slow_clk_in = 4'b0001;
    repeat (3) @(negedge clk_in);
    check("rst_en", 32'(en_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_ovf", 32'(ovf_out), 32'd0);
    check("rst_timeout", 32'(timeout_out), 32'd0);
    rst_n_in = 1'b1;
    at = cyc;
    sb.push_back('{4'b0001, at + 5});
    wait_en("wait_boot_edge");
    job_done(1);
    lower_all();

    // Single edge on ch1; done three cycles after the enable.
    raise(4'b0010, at);
    sb.push_back('{4'b0010, at + 5});
    wait_en("wait_single");
    job_done(3);
    lower_all();

    // ch3 alone, leaving the pointer at 3.
    raise(4'b1000, at);
    sb.push_back('{4'b1000, at + 5});
    wait_en("wait_ch3");
    job_done(1);
    lower_all();

    // Fairness: all four at once, served 0,1,2,3 three cycles apart.
    raise(4'b1111, at);
    e0 = at + 5;
    for (int i = 0; i < 4; i++) sb.push_back('{4'(1 << i), e0 + 3 * i});
    for (int i = 0; i < 4; i++) begin
      wait_en("wait_fair");
      job_done(1);
    end
    lower_all();

    // Saturation: four edges on ch2 while blocked; only the fourth overflows.
    ready_in = 1'b0;
    for (int j = 0; j < 4; j++) begin
      pulse_edge(4'b0100);
      check("ovf_sat", 32'(ovf_out), (j == 3) ? 32'h4 : 32'h0);
    end
    @(negedge clk_in);
    ovf_clr_in = 1'b1;
    @(negedge clk_in);
    ovf_clr_in = 1'b0;
    check("ovf_cleared", 32'(ovf_out), 32'd0);
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back('{4'b0100, -1});
    for (int i = 0; i < 3; i++) begin
      wait_en("wait_sat_drain");
      job_done(1);
    end
    check_none(12, "sat_held_three");

    // Timeout: ch0 never completes; ch1 issues right after forced release.
    raise(4'b0011, at);
    e0 = at + 5;
    sb.push_back('{4'b0001, e0});
    wait_en("wait_to_job");
    repeat (8) @(negedge clk_in);
    check("to_busy_last", 32'(busy_out), 32'd1);
    check("to_flag_early", 32'(timeout_out), 32'd0);
    @(negedge clk_in);
    check("to_busy_rel", 32'(busy_out), 32'd0);
    check("to_flag", 32'(timeout_out), 32'd1);
    sb.push_back('{4'b0010, e0 + 10});
    wait_en("wait_after_to");
    job_done(1);
    @(negedge clk_in);
    ovf_clr_in = 1'b1;
    @(negedge clk_in);
    ovf_clr_in = 1'b0;
    check("to_cleared", 32'(timeout_out), 32'd0);
    lower_all();

    // Disable: two queued ch0 jobs dropped, edges while disabled ignored.
    ready_in = 1'b0;
    pulse_edge(4'b0001);
    pulse_edge(4'b0001);
    ch_enable_in = 4'b1110;
    repeat (2) @(negedge clk_in);
    pulse_edge(4'b0001);
    ch_enable_in = 4'b1111;
    ready_in = 1'b1;
    check_none(15, "disabled_dropped");
    raise(4'b0001, at);
    sb.push_back('{4'b0001, at + 5});
    wait_en("wait_reenabled");
    job_done(1);
    check_none(10, "reenabled_single");
    lower_all();

    // Async reset in WAIT_DONE with ch3 still queued.
    raise(4'b1100, at);
    sb.push_back('{4'b0100, at + 5});
    wait_en("wait_pre_reset");
    @(negedge clk_in);
    check("pre_reset_busy", 32'(busy_out), 32'd1);
    #2 rst_n_in = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy_out), 32'd0);
    check("async_rst_en", 32'(en_out), 32'd0);
    check("async_rst_flags", {31'd0, timeout_out} | 32'(ovf_out), 32'd0);
    slow_clk_in = '0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    check_none(20, "no_en_after_reset");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
